// File: rtl/disp_frame_capture.sv
// Disparity frame capture: packs the integer byte of each valid disparity pixel four-per-word
// and streams the words through a small FIFO to a valid/ready write port, one frame at a time.
module disp_frame_capture #(
  parameter int unsigned WIDTH      = 1920,
  parameter int unsigned HEIGHT     = 1080,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        disp_val,
  input  logic        disp_hs,
  input  logic        disp_vs,
  input  logic [15:0] disp,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_done,
  output logic        overflow,
  output logic        sync_err,
  output logic        busy
);

  localparam int unsigned NumPix = WIDTH * HEIGHT;
  localparam int unsigned PixW   = $clog2(NumPix + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [PixW-1:0] LastPix = PixW'(NumPix - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       pack_q, pack_d;
  logic [31:0]       addr_q, addr_d;
  logic              push_q, push_d;
  logic [31:0]       push_data_q, push_data_d;
  logic [31:0]       push_addr_q, push_addr_d;
  logic              vs_q;
  logic              overflow_q, overflow_d;
  logic              sync_err_q, sync_err_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              wr_valid_q, wr_valid_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   fcnt_q, fcnt_d;
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [31:0]       addr_mem [FIFO_DEPTH];

  logic [7:0] pix_byte;
  logic       vs_rise, fifo_full, push_ok, pop;
  logic       unused_inputs;

  assign unused_inputs = ^{disp_hs, disp[7:0]};
  assign pix_byte      = disp[15:8];
  assign vs_rise       = disp_vs & ~vs_q;
  // Fullness is judged before any same-cycle pop, so a pop never makes room for a push.
  assign fifo_full     = (fcnt_q == FullCnt);
  assign push_ok       = push_q & ~fifo_full;
  assign pop           = wr_valid_q & wr_ready;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    addr_d      = addr_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_addr_d = push_addr_q;
    overflow_d  = overflow_q | (push_q & fifo_full);
    sync_err_d  = sync_err_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d    = StCapture;
          pix_cnt_d  = '0;
          lane_d     = 2'd0;
          addr_d     = BASE_ADDR;
          overflow_d = 1'b0;
          sync_err_d = 1'b0;
        end
      end
      StCapture: begin
        // A new frame sync mid-frame abandons the partial word and restarts geometry.
        if (vs_rise && (pix_cnt_q != '0)) begin
          sync_err_d = 1'b1;
          pix_cnt_d  = '0;
          lane_d     = 2'd0;
          addr_d     = BASE_ADDR;
        end
        if (disp_val) begin
          if (lane_d == 2'd3) begin
            push_d      = 1'b1;
            push_data_d = {pix_byte, pack_d};
            push_addr_d = addr_d;
            addr_d      = addr_d + 32'd4;
          end else begin
            pack_d[{lane_d, 3'b000} +: 8] = pix_byte;
          end
          lane_d = lane_d + 2'd1;
          if (pix_cnt_d == LastPix) begin
            state_d = StDrain;
          end
          pix_cnt_d = pix_cnt_d + PixW'(1);
        end
      end
      StDrain: begin
        if ((fcnt_q == '0) && !push_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (enable) begin
          state_d   = StCapture;
          pix_cnt_d = '0;
          lane_d    = 2'd0;
          addr_d    = BASE_ADDR;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    frame_done_d = (state_d == StDone);
    busy_d       = (state_d != StIdle);

    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    fcnt_d   = fcnt_q + CntW'(push_ok) - CntW'(pop);
    // A freshly pushed word becomes visible one cycle after it lands in the FIFO.
    wr_valid_d = pop ? (fcnt_q != CntW'(1)) : (fcnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      pix_cnt_q    <= '0;
      lane_q       <= 2'd0;
      pack_q       <= '0;
      addr_q       <= BASE_ADDR;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_addr_q  <= BASE_ADDR;
      vs_q         <= 1'b0;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      addr_q       <= addr_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      push_addr_q  <= push_addr_d;
      vs_q         <= disp_vs;
      overflow_q   <= overflow_d;
      sync_err_q   <= sync_err_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      wr_valid_q   <= wr_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
    end
  end

  // Storage is cleared on reset so the write port shows BASE_ADDR / zero data afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= BASE_ADDR;
      end
    end else if (push_ok) begin
      data_mem[wr_ptr_q] <= push_data_q;
      addr_mem[wr_ptr_q] <= push_addr_q;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_addr    = addr_mem[rd_ptr_q];
  assign wr_data    = data_mem[rd_ptr_q];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_disp_frame_capture.sv
// Bench for disp_frame_capture: scoreboard of expected {addr,data} writes per instance,
// one task per scenario; instance a is 8x2 with a 16-deep FIFO, instance b is 8x8 with 4.
module tb_disp_frame_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, disp_val, disp_hs, disp_vs, wr_ready;
  logic [15:0] disp;
  logic        wr_valid, frame_done, overflow, sync_err, busy;
  logic [31:0] wr_addr, wr_data;

  logic        b_enable, b_val, b_vs, b_ready;
  logic [15:0] b_disp;
  logic        b_wr_valid, b_frame_done, b_overflow, b_sync_err, b_busy;
  logic [31:0] b_wr_addr, b_wr_data;

  int n_vec = 0;
  int n_err = 0;
  int fd_a  = 0;
  int fd_b  = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [63:0] ea, eb, held_a;
  logic        hold_a = 1'b0, fd_prev_a = 1'b0, fd_prev_b = 1'b0;
  logic [31:0] m_word, m_addr;
  int          m_lane;

  disp_frame_capture #(
    .WIDTH(8), .HEIGHT(2), .BASE_ADDR(32'h0000_0000), .FIFO_DEPTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .disp_val(disp_val), .disp_hs(disp_hs),
    .disp_vs(disp_vs), .disp(disp), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .overflow(overflow),
    .sync_err(sync_err), .busy(busy)
  );

  disp_frame_capture #(
    .WIDTH(8), .HEIGHT(8), .BASE_ADDR(32'h0000_0000), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .disp_val(b_val), .disp_hs(b_val),
    .disp_vs(b_vs), .disp(b_disp), .wr_valid(b_wr_valid), .wr_ready(b_ready),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .frame_done(b_frame_done),
    .overflow(b_overflow), .sync_err(b_sync_err), .busy(b_busy)
  );

  // Write-port monitors: scoreboard pop/compare, hold stability, frame_done pulse width.
  always @(negedge clk) begin
    if (hold_a) begin
      n_vec++;
      if (wr_valid !== 1'b1 || {wr_addr, wr_data} !== held_a) begin
        n_err++;
        $display("FAIL a_hold_stable: got valid=%b addr/data=%h, required 1/%h",
                 wr_valid, {wr_addr, wr_data}, held_a);
      end
    end
    if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
      n_vec++;
      if (exp_a.size() == 0) begin
        n_err++;
        $display("FAIL a_unexpected_write: got addr=%h data=%h, required no write",
                 wr_addr, wr_data);
      end else begin
        ea = exp_a.pop_front();
        if ({wr_addr, wr_data} !== ea) begin
          n_err++;
          $display("FAIL a_write: got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, ea[63:32], ea[31:0]);
        end
      end
    end
    if (frame_done === 1'b1) begin
      fd_a++;
      n_vec++;
      if (fd_prev_a) begin
        n_err++;
        $display("FAIL a_frame_done_width: got high 2 cycles, required 1");
      end
    end
    fd_prev_a = (frame_done === 1'b1);
    hold_a    = rst && wr_valid && !wr_ready;
    held_a    = {wr_addr, wr_data};
  end

  always @(negedge clk) begin
    if (b_wr_valid === 1'b1 && b_ready === 1'b1) begin
      n_vec++;
      if (exp_b.size() == 0) begin
        n_err++;
        $display("FAIL b_unexpected_write: got addr=%h data=%h, required no write",
                 b_wr_addr, b_wr_data);
      end else begin
        eb = exp_b.pop_front();
        if ({b_wr_addr, b_wr_data} !== eb) begin
          n_err++;
          $display("FAIL b_write: got addr=%h data=%h, required addr=%h data=%h",
                   b_wr_addr, b_wr_data, eb[63:32], eb[31:0]);
        end
      end
    end
    if (b_frame_done === 1'b1) begin
      fd_b++;
      n_vec++;
      if (fd_prev_b) begin
        n_err++;
        $display("FAIL b_frame_done_width: got high 2 cycles, required 1");
      end
    end
    fd_prev_b = (b_frame_done === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lane = 0;
    m_addr = 32'h0;
    m_word = 32'h0;
  endtask

  // Drive one pixel on instance a; the model queues a word when lane 3 is driven.
  task automatic pix_a(input logic [7:0] b, input bit model);
    if (model) begin
      m_word = {b, m_word[31:8]};
      if (m_lane == 3) begin
        exp_a.push_back({m_addr, m_word});
        m_addr = m_addr + 32'd4;
      end
      m_lane = (m_lane + 1) % 4;
    end
    disp_val = 1'b1;
    disp_hs  = 1'b1;
    disp     = {b, 8'hA5};
    step();
    disp_val = 1'b0;
    disp_hs  = 1'b0;
  endtask

  // Instance b with a stalled port keeps only the first four words.
  task automatic pix_b(input logic [7:0] b);
    m_word = {b, m_word[31:8]};
    if (m_lane == 3) begin
      if (m_addr < 32'd16) exp_b.push_back({m_addr, m_word});
      m_addr = m_addr + 32'd4;
    end
    m_lane = (m_lane + 1) % 4;
    b_val  = 1'b1;
    b_disp = {b, 8'h3C};
    step();
    b_val  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_vec++;
    if ({wr_valid, frame_done, overflow, sync_err, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 00000",
               {wr_valid, frame_done, overflow, sync_err, busy});
    end
    n_vec++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_port: got addr=%h data=%h, required 0/0", wr_addr, wr_data);
    end
    n_vec++;
    if ({b_wr_valid, b_busy, b_overflow} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_b: got %b, required 000", {b_wr_valid, b_busy, b_overflow});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    int f0 = fd_a;
    model_reset();
    wr_ready = 1'b1;
    enable   = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy: got %b, required 1", busy);
    end
    for (int k = 1; k <= 16; k++) begin
      pix_a(8'(k), 1'b1);
      if (k == 5) begin
        n_vec++;
        if (wr_valid !== 1'b0) begin
          n_err++;
          $display("FAIL single_latency_early: got wr_valid=%b, required 0", wr_valid);
        end
      end
      if (k == 6) begin
        n_vec++;
        if (wr_valid !== 1'b1) begin
          n_err++;
          $display("FAIL single_latency: got wr_valid=%b, required 1", wr_valid);
        end
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 100 && fd_a == f0; i++) step();
    step();
    step();
    n_vec++;
    if (fd_a - f0 != 1) begin
      n_err++;
      $display("FAIL single_frame_done: got %0d pulses, required 1", fd_a - f0);
    end
    n_vec++;
    if (overflow !== 1'b0 || busy !== 1'b0 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL single_end: got ovf=%b busy=%b pending=%0d, required 0/0/0",
               overflow, busy, exp_a.size());
    end
  endtask

  task automatic test_backpressure();
    int f0 = fd_a;
    model_reset();
    wr_ready = 1'b0;
    enable   = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 1; k <= 16; k++) pix_a(8'(8'h40 + k), 1'b1);
    for (int i = 0; i < 13; i++) step();
    n_vec++;
    if (wr_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stalled: got valid=%b busy=%b, required 1/1", wr_valid, busy);
    end
    wr_ready = 1'b1;
    for (int i = 0; i < 100 && fd_a == f0; i++) step();
    step();
    n_vec++;
    if (fd_a == f0 || overflow !== 1'b0 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL bp_end: got done=%0d ovf=%b pending=%0d, required 1/0/0",
               fd_a - f0, overflow, exp_a.size());
    end
  endtask

  task automatic test_overflow();
    int f0 = fd_b;
    model_reset();
    b_ready  = 1'b0;
    b_enable = 1'b1;
    step();
    b_enable = 1'b0;
    for (int k = 1; k <= 64; k++) pix_b(8'(k));
    step();
    step();
    step();
    n_vec++;
    if (b_overflow !== 1'b1 || b_busy !== 1'b1 || b_wr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got ovf=%b busy=%b valid=%b, required 1/1/1",
               b_overflow, b_busy, b_wr_valid);
    end
    b_ready = 1'b1;
    for (int i = 0; i < 100 && fd_b == f0; i++) step();
    step();
    n_vec++;
    if (fd_b - f0 != 1 || exp_b.size() != 0 || b_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_end: got done=%0d pending=%0d ovf=%b, required 1/0/1",
               fd_b - f0, exp_b.size(), b_overflow);
    end
  endtask

  task automatic test_sync_err();
    int f0 = fd_a;
    model_reset();
    wr_ready = 1'b1;
    enable   = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 1; k <= 6; k++) pix_a(8'(k), 1'b1);
    disp_vs = 1'b1;
    step();
    disp_vs = 1'b0;
    n_vec++;
    if (sync_err !== 1'b1) begin
      n_err++;
      $display("FAIL sync_flag: got %b, required 1", sync_err);
    end
    model_reset();
    for (int k = 21; k <= 36; k++) pix_a(8'(k), 1'b1);
    for (int i = 0; i < 100 && fd_a == f0; i++) step();
    step();
    n_vec++;
    if (fd_a - f0 != 1 || exp_a.size() != 0 || sync_err !== 1'b1) begin
      n_err++;
      $display("FAIL sync_end: got done=%0d pending=%0d sync_err=%b, required 1/0/1",
               fd_a - f0, exp_a.size(), sync_err);
    end
  endtask

  task automatic test_enable_drop();
    int f0 = fd_a;
    int f1;
    model_reset();
    wr_ready = 1'b1;
    enable   = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) pix_a(8'(8'h80 + k), 1'b1);
    enable = 1'b0;
    for (int k = 6; k <= 16; k++) pix_a(8'(8'h80 + k), 1'b1);
    for (int i = 0; i < 100 && fd_a == f0; i++) step();
    step();
    n_vec++;
    if (fd_a - f0 != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL endrop_done: got done=%0d busy=%b, required 1/0", fd_a - f0, busy);
    end
    f1 = fd_a;
    for (int k = 0; k < 8; k++) pix_a(8'(8'hE0 + k), 1'b0);
    for (int i = 0; i < 10; i++) step();
    n_vec++;
    if (busy !== 1'b0 || fd_a != f1 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL endrop_ignored: got busy=%b done=%0d pending=%0d, required 0/0/0",
               busy, fd_a - f1, exp_a.size());
    end
  endtask

  task automatic test_reset_drain();
    int f0 = fd_a;
    model_reset();
    wr_ready = 1'b0;
    enable   = 1'b1;
    step();
    enable = 1'b0;
    for (int k = 1; k <= 16; k++) pix_a(8'(8'hC0 + k), 1'b1);
    step();
    step();
    step();
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    n_vec++;
    if (exp_a.size() != 3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstdrain_setup: got pending=%0d busy=%b, required 3/1",
               exp_a.size(), busy);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_vec++;
    if ({wr_valid, frame_done, overflow, sync_err, busy} !== 5'b0 ||
        wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      n_err++;
      $display("FAIL rstdrain_outputs: got flags=%b addr=%h data=%h, required 0/0/0",
               {wr_valid, frame_done, overflow, sync_err, busy}, wr_addr, wr_data);
    end
    exp_a.delete();
    wr_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_vec++;
    if (busy !== 1'b0 || wr_valid !== 1'b0 || fd_a != f0) begin
      n_err++;
      $display("FAIL rstdrain_idle: got busy=%b valid=%b done=%0d, required 0/0/0",
               busy, wr_valid, fd_a - f0);
    end
  endtask

  task automatic test_back_to_back();
    int f0 = fd_a;
    wr_ready = 1'b1;
    enable   = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      model_reset();
      for (int ln = 0; ln < 2; ln++) begin
        for (int x = 0; x < 8; x++) begin
          disp_vs = (ln == 0 && x == 0);
          pix_a(8'(8'h10 + f * 16 + ln * 8 + x), 1'b1);
          disp_vs = 1'b0;
        end
        if (f == 1) enable = 1'b0;
        for (int i = 0; i < 20; i++) step();
      end
    end
    for (int i = 0; i < 100 && fd_a - f0 < 2; i++) step();
    step();
    n_vec++;
    if (fd_a - f0 != 2 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL b2b_frames: got done=%0d pending=%0d, required 2/0",
               fd_a - f0, exp_a.size());
    end
    n_vec++;
    if (sync_err !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_flags: got sync=%b ovf=%b busy=%b, required 0/0/0",
               sync_err, overflow, busy);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    enable   = 1'b0;
    disp_val = 1'b0;
    disp_hs  = 1'b0;
    disp_vs  = 1'b0;
    disp     = 16'h0;
    wr_ready = 1'b0;
    b_enable = 1'b0;
    b_val    = 1'b0;
    b_vs     = 1'b0;
    b_disp   = 16'h0;
    b_ready  = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_sync_err();
    test_enable_drop();
    test_reset_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
